sevenseg_scan: RTL and testbench
================================

# sevenseg_scan

Time-multiplexed driver for a common-anode bank of NUM_DIGITS seven-segment digits with decimal points, the generalised successor of our single-digit decoder. Takes packed BCD/hex nibbles and per-digit decimal points, scans one digit at a time at a programmable rate, and adds leading-zero blanking, per-digit enables, anti-ghosting dead time and tear-free frame snapshots. It sits between stopwatch/counter logic and the board pins.

## Interface
- NUM_DIGITS, 8, digits in the bank; legal 2..16
- SCAN_DIV, 50000, clk cycles each digit is selected; legal > BLANK_CYC
- BLANK_CYC, 2, dead-time cycles at the start of each digit slot with all anodes off; legal 0..SCAN_DIV-1
- HEX_EN, 0, 1: nibbles 10..15 show A b C d E F; 0: they show blank
- clk  in  1  single clock; all logic on its rising edge
- reset  in  1  synchronous, active-high
- data  in  4*NUM_DIGITS  nibble i = data[4i+3:4i]; digit 0 least significant
- dp_in  in  NUM_DIGITS  1 = decimal point lit on digit i
- digit_en  in  NUM_DIGITS  1 = digit i may be driven; 0 = anode held off
- blank_lz  in  1  1 = suppress leading zeros
- an  out  NUM_DIGITS  anode selects, active-low
- seg  out  7  segments a..g = seg[6:0], active-low
- dp  out  1  decimal point, active-low
- frame_tick  out  1  one-cycle pulse when the scan wraps to digit 0

## Operation
- Prescaler pcnt counts 0..SCAN_DIV-1, wraps to 0. At pcnt==SCAN_DIV-1, digit index idx increments; idx==NUM_DIGITS-1 wraps to 0.
- Shadow registers (nibbles, dp_in, digit_en, blank_lz) load from inputs on the cycle that idx wraps to 0, and on the first cycle after reset deasserts (load_pending flag set by reset). Inputs changing mid-frame never affect the frame being shown.
- Glyphs (7-bit hex, active-low): 0=01 1=4F 2=12 3=06 4=4C 5=24 6=20 7=0F 8=00 9=04; with HEX_EN A=08 b=60 C=31 d=42 E=30 F=38; blank=7F.
- Leading-zero blank: with shadow blank_lz=1, digit i (i>0) is blank when its nibble and every nibble above it are 0. Digit 0 is never zero-blanked. dp on a blanked digit still follows dp_in.
- Digit with shadow digit_en=0: an[i] stays 1 for its whole slot; the slot time is still spent (no skipping, constant refresh rate).
- Dead time: while pcnt < BLANK_CYC, an = all ones; seg/dp already show the new digit.
- At most one an bit is 0 at any time.

## Timing
- Reset values: pcnt=0, idx=0, an=all ones, seg=7F, dp=1, frame_tick=0, shadow=0, load_pending=1.
- an/seg/dp/frame_tick are registered: they reflect pcnt/idx/shadow of the previous cycle (1-cycle latency).
- frame_tick high for exactly the one output cycle following the idx wrap to 0; period NUM_DIGITS*SCAN_DIV cycles.
- Each digit: an[i] low for SCAN_DIV-BLANK_CYC cycles per frame.
- Reset asserted mid-scan: all outputs return to reset values on the next edge; scan restarts at digit 0 with a fresh snapshot.
- Shadow load and idx wrap in the same cycle: the new snapshot is used for digit 0 of the new frame.

## Structure
- Shared package sevenseg_pkg: glyph constants (GLYPH_0..GLYPH_F, GLYPH_BLANK), segment bit-order and active-low polarity constants.
- One sub-module: sevenseg_glyph, combinational nibble + hex_en -> 7-bit glyph; the scan block instantiates it once on the muxed nibble.

## Test plan
Bench uses NUM_DIGITS=4, SCAN_DIV=4, BLANK_CYC=1, HEX_EN=0 unless stated.
- Reset held 3 cycles -> an=4'hF, seg=7F, dp=1, frame_tick=0 throughout; first frame_tick 16 cycles after release period 16.
- data=16'h1234, dp_in=0, blank_lz=0 -> per slot an=F then E/D/B/7 for 3 cycles each, seg 4C,06,12,4F.
- data=16'h0050, blank_lz=1 -> digits 3,2 seg=7F, digit1 24, digit0 01; data=0 -> only digit0 shows 01.
- HEX_EN=1, data=16'hABCF -> seg 38,31,60,08; HEX_EN=0 same data -> all 7F.
- data changed 1234->5678 mid-frame -> remainder of frame still shows 1234; next frame shows 5678.
- digit_en=4'b0101, dp_in=4'b0001 -> an[1], an[3] never low; dp=0 only during digit 0 slot; reset asserted at idx=2 -> next cycle reset values, scan restarts at digit 0.

Source files
------------

// File: rtl/sevenseg_pkg.sv
//------------------------------------------------------------------------------
// sevenseg_pkg
//   Shared constants for the seven-segment display blocks: glyph patterns,
//   segment bit positions and drive polarity.
//   Segment order: seg[6:0] = {a,b,c,d,e,f,g}; all segments active-low.
// Revision: 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package sevenseg_pkg;

  // Bit positions of each segment inside the 7-bit glyph
  localparam int SEG_A_BIT = 6;
  localparam int SEG_B_BIT = 5;
  localparam int SEG_C_BIT = 4;
  localparam int SEG_D_BIT = 3;
  localparam int SEG_E_BIT = 2;
  localparam int SEG_F_BIT = 1;
  localparam int SEG_G_BIT = 0;

  // Drive polarity of segments, decimal point and anodes
  localparam logic SEG_ON  = 1'b0;
  localparam logic SEG_OFF = 1'b1;

  localparam logic [6:0] GLYPH_0     = 7'h01;
  localparam logic [6:0] GLYPH_1     = 7'h4F;
  localparam logic [6:0] GLYPH_2     = 7'h12;
  localparam logic [6:0] GLYPH_3     = 7'h06;
  localparam logic [6:0] GLYPH_4     = 7'h4C;
  localparam logic [6:0] GLYPH_5     = 7'h24;
  localparam logic [6:0] GLYPH_6     = 7'h20;
  localparam logic [6:0] GLYPH_7     = 7'h0F;
  localparam logic [6:0] GLYPH_8     = 7'h00;
  localparam logic [6:0] GLYPH_9     = 7'h04;
  localparam logic [6:0] GLYPH_A     = 7'h08;
  localparam logic [6:0] GLYPH_B     = 7'h60;
  localparam logic [6:0] GLYPH_C     = 7'h31;
  localparam logic [6:0] GLYPH_D     = 7'h42;
  localparam logic [6:0] GLYPH_E     = 7'h30;
  localparam logic [6:0] GLYPH_F     = 7'h38;
  localparam logic [6:0] GLYPH_BLANK = {7{SEG_OFF}};

endpackage

`default_nettype wire

// File: rtl/sevenseg_glyph.sv
//------------------------------------------------------------------------------
// sevenseg_glyph
//   Combinational nibble to seven-segment glyph decoder (active-low).
//   Ports:
//     nibble  in  4  value to display
//     hex_en  in  1  1: 10..15 show A b C d E F; 0: they show blank
//     glyph   out 7  segments {a..g}, active-low
// Revision: 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module sevenseg_glyph
  import sevenseg_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       hex_en,
  output logic [6:0] glyph
);

  always_comb begin
    glyph = GLYPH_BLANK;
    unique case (nibble)
      4'h0: glyph = GLYPH_0;
      4'h1: glyph = GLYPH_1;
      4'h2: glyph = GLYPH_2;
      4'h3: glyph = GLYPH_3;
      4'h4: glyph = GLYPH_4;
      4'h5: glyph = GLYPH_5;
      4'h6: glyph = GLYPH_6;
      4'h7: glyph = GLYPH_7;
      4'h8: glyph = GLYPH_8;
      4'h9: glyph = GLYPH_9;
      4'hA: glyph = hex_en ? GLYPH_A : GLYPH_BLANK;
      4'hB: glyph = hex_en ? GLYPH_B : GLYPH_BLANK;
      4'hC: glyph = hex_en ? GLYPH_C : GLYPH_BLANK;
      4'hD: glyph = hex_en ? GLYPH_D : GLYPH_BLANK;
      4'hE: glyph = hex_en ? GLYPH_E : GLYPH_BLANK;
      4'hF: glyph = hex_en ? GLYPH_F : GLYPH_BLANK;
      default: glyph = GLYPH_BLANK;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/sevenseg_scan.sv
//------------------------------------------------------------------------------
// sevenseg_scan
//   Time-multiplexed driver for a common-anode bank of seven-segment digits
//   with leading-zero blanking, per-digit enables, anti-ghosting dead time
//   and per-frame input snapshots.
//   Ports:
//     clk         in  1             rising-edge clock
//     reset       in  1             synchronous, active-high
//     data        in  4*NUM_DIGITS  nibble i = data[4i+3:4i]
//     dp_in       in  NUM_DIGITS    1 = decimal point lit on digit i
//     digit_en    in  NUM_DIGITS    1 = digit i may be driven
//     blank_lz    in  1             1 = suppress leading zeros
//     an          out NUM_DIGITS    anode selects, active-low
//     seg         out 7             segments a..g = seg[6:0], active-low
//     dp          out 1             decimal point, active-low
//     frame_tick  out 1             one-cycle pulse at scan wrap to digit 0
// Revision: 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module sevenseg_scan
  import sevenseg_pkg::*;
#(
  parameter int NUM_DIGITS = 8,
  parameter int SCAN_DIV   = 50000,
  parameter int BLANK_CYC  = 2,
  parameter int HEX_EN     = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] data,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic                    blank_lz,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic                    frame_tick
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [PW-1:0] PCNT_LAST = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0] PCNT_LIT  = PW'(BLANK_CYC);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

  logic [PW-1:0]             pcnt_q, pcnt_d;
  logic [IW-1:0]             idx_q, idx_d;
  logic                      load_pending_q;
  logic [4*NUM_DIGITS-1:0]   data_q;
  logic [NUM_DIGITS-1:0]     dp_q;
  logic [NUM_DIGITS-1:0]     en_q;
  logic                      blz_q;

  logic [NUM_DIGITS-1:0]     an_d;
  logic [6:0]                seg_d;
  logic                      dp_d;

  logic                      slot_end;
  logic                      frame_wrap;
  logic                      shadow_load;
  logic [3:0]                nib_sel;
  logic [6:0]                glyph_sel;
  logic [NUM_DIGITS-1:0]     zero_above;
  logic                      lz_blank;

  assign slot_end    = (pcnt_q == PCNT_LAST);
  assign frame_wrap  = slot_end && (idx_q == IDX_LAST);
  // The wrap-cycle snapshot is what digit 0 of the next frame displays
  assign shadow_load = frame_wrap || load_pending_q;
  assign nib_sel     = data_q[{idx_q, 2'b00} +: 4];

  // zero_above[i]: nibble i and every nibble above it are zero
  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_lz
    if (i == NUM_DIGITS - 1) begin : g_top
      assign zero_above[i] = (data_q[4*i +: 4] == 4'h0);
    end else begin : g_mid
      assign zero_above[i] = (data_q[4*i +: 4] == 4'h0) && zero_above[i+1];
    end
  end

  assign lz_blank = blz_q && (idx_q != '0) && zero_above[idx_q];

  sevenseg_glyph u_glyph (
    .nibble (nib_sel),
    .hex_en (HEX_EN != 0),
    .glyph  (glyph_sel)
  );

  always_comb begin
    pcnt_d = slot_end ? '0 : pcnt_q + 1'b1;
    idx_d  = idx_q;
    if (slot_end) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end

    // Only one anode can ever be cleared; dead time and disabled digits
    // leave all anodes off while the slot still elapses.
    an_d = '1;
    if ((pcnt_q >= PCNT_LIT) && en_q[idx_q]) begin
      an_d[idx_q] = 1'b0;
    end
    seg_d = lz_blank ? GLYPH_BLANK : glyph_sel;
    dp_d  = dp_q[idx_q] ? SEG_ON : SEG_OFF;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pcnt_q         <= '0;
      idx_q          <= '0;
      load_pending_q <= 1'b1;
      data_q         <= '0;
      dp_q           <= '0;
      en_q           <= '0;
      blz_q          <= 1'b0;
      an             <= '1;
      seg            <= GLYPH_BLANK;
      dp             <= SEG_OFF;
      frame_tick     <= 1'b0;
    end else begin
      pcnt_q         <= pcnt_d;
      idx_q          <= idx_d;
      load_pending_q <= 1'b0;
      if (shadow_load) begin
        data_q <= data;
        dp_q   <= dp_in;
        en_q   <= digit_en;
        blz_q  <= blank_lz;
      end
      an         <= an_d;
      seg        <= seg_d;
      dp         <= dp_d;
      frame_tick <= frame_wrap;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sevenseg_scan.sv
//------------------------------------------------------------------------------
// tb_sevenseg_scan
//   Scoreboard bench for sevenseg_scan: a stimulus process pushes the
//   expected lit-cycle outputs of each frame, a monitor pops and compares
//   them whenever an anode is driven. Two instances (HEX_EN=0 and 1) run
//   in lockstep on the same inputs.
// Revision: 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_sevenseg_scan;

  localparam int N   = 4;
  localparam int SD  = 4;
  localparam int BC  = 1;
  localparam int LIT = SD - BC;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic [6:0] segh;
    logic       dp;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [15:0]   data = 16'h1234;
  logic [3:0]    dp_in = 4'h0;
  logic [3:0]    digit_en = 4'hF;
  logic          blank_lz = 1'b0;
  logic [3:0]    an, an_h;
  logic [6:0]    seg, seg_h;
  logic          dp, dp_h, tick, tick_h;

  exp_t          q[$];
  int            total = 0;
  int            bad = 0;

  always #5 clk = ~clk;

  sevenseg_scan #(.NUM_DIGITS(N), .SCAN_DIV(SD), .BLANK_CYC(BC), .HEX_EN(0)) dut (
    .clk(clk), .reset(reset), .data(data), .dp_in(dp_in), .digit_en(digit_en),
    .blank_lz(blank_lz), .an(an), .seg(seg), .dp(dp), .frame_tick(tick)
  );

  sevenseg_scan #(.NUM_DIGITS(N), .SCAN_DIV(SD), .BLANK_CYC(BC), .HEX_EN(1)) dut_hex (
    .clk(clk), .reset(reset), .data(data), .dp_in(dp_in), .digit_en(digit_en),
    .blank_lz(blank_lz), .an(an_h), .seg(seg_h), .dp(dp_h), .frame_tick(tick_h)
  );

  // Monitor: one-hot anode check every cycle, scoreboard pop on lit cycles
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!reset) begin
        total++;
        if ($countones(~an) > 1) begin
          bad++;
          $display("FAIL onehot an=%h", an);
        end
        if (an != 4'hF && q.size() > 0) begin
          e = q.pop_front();
          total++;
          if ({an, seg, seg_h, dp} !== {e.an, e.seg, e.segh, e.dp}) begin
            bad++;
            $display("FAIL slot got an=%h seg=%h segh=%h dp=%b want an=%h seg=%h segh=%h dp=%b",
                     an, seg, seg_h, dp, e.an, e.seg, e.segh, e.dp);
          end
        end
      end
    end
  end

  task automatic push_slot(input logic [3:0] a, input logic [6:0] s,
                           input logic [6:0] sh, input logic d);
    exp_t e;
    e = '{an: a, seg: s, segh: sh, dp: d};
    for (int k = 0; k < LIT; k++) q.push_back(e);
  endtask

  task automatic check_reset_vals(input string name);
    total++;
    if ({an, seg, dp, tick} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL %s got an=%h seg=%h dp=%b tick=%b want an=f seg=7f dp=1 tick=0",
               name, an, seg, dp, tick);
    end
  endtask

  // Waits at negedges for frame_tick; new frame's digit 0 follows
  task automatic wait_tick();
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (tick) return;
    end
    total++;
    bad++;
    $display("FAIL tick_timeout got none want tick within 60 cycles");
  endtask

  task automatic count_to_tick(input string name, input int want);
    int n;
    n = 0;
    for (int k = 0; k < 60; k++) begin
      @(posedge clk);
      #1;
      n++;
      if (tick) break;
    end
    total++;
    if (n != want) begin
      bad++;
      $display("FAIL %s got %0d want %0d", name, n, want);
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (q.size() == 0) return;
    end
    total++;
    bad++;
    $display("FAIL drain got %0d pending want 0", q.size());
    q.delete();
  endtask

  initial begin
    // Reset held three cycles
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_reset_vals("reset_hold");
    end
    reset = 1'b0;
    count_to_tick("first_tick", 16);
    count_to_tick("tick_period", 16);

    // 1234, then a mid-frame change to 5678
    @(negedge clk);
    wait_tick();
    push_slot(4'hE, 7'h4C, 7'h4C, 1'b1);
    push_slot(4'hD, 7'h06, 7'h06, 1'b1);
    push_slot(4'hB, 7'h12, 7'h12, 1'b1);
    push_slot(4'h7, 7'h4F, 7'h4F, 1'b1);
    repeat (6) @(negedge clk);
    data = 16'h5678;
    wait_tick();
    push_slot(4'hE, 7'h00, 7'h00, 1'b1);
    push_slot(4'hD, 7'h0F, 7'h0F, 1'b1);
    push_slot(4'hB, 7'h20, 7'h20, 1'b1);
    push_slot(4'h7, 7'h24, 7'h24, 1'b1);
    drain();

    // Leading-zero blanking
    data = 16'h0050;
    blank_lz = 1'b1;
    wait_tick();
    push_slot(4'hE, 7'h01, 7'h01, 1'b1);
    push_slot(4'hD, 7'h24, 7'h24, 1'b1);
    push_slot(4'hB, 7'h7F, 7'h7F, 1'b1);
    push_slot(4'h7, 7'h7F, 7'h7F, 1'b1);
    drain();
    data = 16'h0000;
    wait_tick();
    push_slot(4'hE, 7'h01, 7'h01, 1'b1);
    push_slot(4'hD, 7'h7F, 7'h7F, 1'b1);
    push_slot(4'hB, 7'h7F, 7'h7F, 1'b1);
    push_slot(4'h7, 7'h7F, 7'h7F, 1'b1);
    drain();

    // Hex letters: blank without HEX_EN, A b C F with it
    data = 16'hABCF;
    blank_lz = 1'b0;
    wait_tick();
    push_slot(4'hE, 7'h7F, 7'h38, 1'b1);
    push_slot(4'hD, 7'h7F, 7'h31, 1'b1);
    push_slot(4'hB, 7'h7F, 7'h60, 1'b1);
    push_slot(4'h7, 7'h7F, 7'h08, 1'b1);
    drain();

    // Digit enables and decimal point
    data = 16'h1234;
    digit_en = 4'b0101;
    dp_in = 4'b0001;
    wait_tick();
    push_slot(4'hE, 7'h4C, 7'h4C, 1'b0);
    push_slot(4'hB, 7'h12, 7'h12, 1'b1);
    drain();

    // Reset during digit 2 slot, then restart with a fresh snapshot
    begin
      bit seen;
      seen = 1'b0;
      for (int k = 0; k < 60 && !seen; k++) begin
        @(negedge clk);
        if (an == 4'hB) seen = 1'b1;
      end
      total++;
      if (!seen) begin
        bad++;
        $display("FAIL reach_digit2 got an=%h want b within 60 cycles", an);
      end
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_reset_vals("mid_reset");
    @(negedge clk);
    data = 16'h5678;
    reset = 1'b0;
    push_slot(4'hE, 7'h00, 7'h00, 1'b0);
    push_slot(4'hB, 7'h20, 7'h20, 1'b1);
    count_to_tick("restart_tick", 16);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
